// File: rtl/control_unit_pkg.sv
// Shared definitions for the control sequencer: opcodes, state encoding, strobe-bus layout
// and instruction classes. CTRL_STOP_EN adds the STOP state.
package control_unit_pkg;

  localparam int OPCODE_W = 5;
  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHRA = 5'b01000;
  localparam opcode_t OP_SHL  = 5'b01001, OP_ROR  = 5'b01010, OP_ROL  = 5'b01011;
  localparam opcode_t OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
  localparam opcode_t OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
  localparam opcode_t OP_IN   = 5'b10110, OP_OUT  = 5'b10111, OP_MFHI = 5'b11000;
  localparam opcode_t OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
  localparam opcode_t HALT_OP_DEFAULT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef CTRL_STOP_EN
    , S_STOP
`endif
  } state_t;

  // Field order is the bit map of the strobe vector (HIin is the MSB).
  typedef struct packed {
    logic HIin, LOin, HIout, LOout, Zhighin, Zlowin, Zhighout, Zlowout;
    logic PCin, PCout, MDRin, MDRout, MARin, MDMuxread, RAMread, RAMwrite, IRin, Yin;
    logic InPortout, OutPortin, CSEout, CONin, Gra, Grb, Grc, Rin, Rout, BAout, IncPC;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  } strobe_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LD, C_ST, C_MULDIV, C_NEGNOT, C_BR, C_SINGLE, C_NOP, C_HALT
  } iclass_t;

  function automatic iclass_t instr_class(input opcode_t op, input opcode_t halt_op);
    iclass_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:            c = C_RTYPE;
      OP_LDI, OP_ADDI, OP_ANDI, OP_ORI:           c = C_IMM;
      OP_LD:                                      c = C_LD;
      OP_ST:                                      c = C_ST;
      OP_MUL, OP_DIV:                             c = C_MULDIV;
      OP_NEG, OP_NOT:                             c = C_NEGNOT;
      OP_BR:                                      c = C_BR;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:     c = C_SINGLE;
      default:                                    c = C_NOP;
    endcase
    if (op == halt_op) c = C_HALT;
    return c;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the sequencer and the Datapath.
interface control_unit_if ();
  import control_unit_pkg::*;

  // Level signalling, no handshake: every strobe is valid for the whole clock of the
  // state that drives it; IR and ConFFQ are sampled combinationally by the sequencer.
  logic [31:0] IR;
  logic        ConFFQ;
  logic        run;
  strobe_t     strb;

  modport master (input IR, input ConFFQ, output run, output strb);
  modport slave  (output IR, output ConFFQ, input run, input strb);
endinterface

// File: rtl/control_unit_decode.sv
// Output decode of the sequencer: {state, opcode, ConFFQ} -> strobe vector and run.
module control_decode
  import control_unit_pkg::*;
#(
  parameter opcode_t HALT_OP = HALT_OP_DEFAULT
) (
  input  state_t  i_state,
  input  opcode_t i_opcode,
  input  logic    i_con,
  output strobe_t o_strb,
  output logic    o_run
);

  iclass_t w_class;
  assign w_class = instr_class(i_opcode, HALT_OP);
  assign o_run   = i_state inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7};

  always_comb begin
    o_strb = '0;
    case (i_state)
      S_T0: begin o_strb.PCout = 1'b1; o_strb.MARin = 1'b1; o_strb.IncPC = 1'b1; o_strb.Zlowin = 1'b1; end
      S_T1: begin
        o_strb.Zlowout = 1'b1; o_strb.PCin = 1'b1; o_strb.MDMuxread = 1'b1;
        o_strb.RAMread = 1'b1; o_strb.MDRin = 1'b1;
      end
      S_T2: begin o_strb.MDRout = 1'b1; o_strb.IRin = 1'b1; end
      S_T3: begin
        case (w_class)
          C_RTYPE:    begin o_strb.Grb = 1'b1; o_strb.Rout = 1'b1; o_strb.Yin = 1'b1; end
          C_IMM: begin
            o_strb.Grb = 1'b1; o_strb.Yin = 1'b1;
            if (i_opcode == OP_LDI) o_strb.BAout = 1'b1;
            else                    o_strb.Rout  = 1'b1;
          end
          C_LD, C_ST: begin o_strb.Grb = 1'b1; o_strb.BAout = 1'b1; o_strb.Yin = 1'b1; end
          C_MULDIV:   begin o_strb.Gra = 1'b1; o_strb.Rout = 1'b1; o_strb.Yin = 1'b1; end
          C_NEGNOT: begin
            o_strb.Grb = 1'b1; o_strb.Rout = 1'b1; o_strb.Zlowin = 1'b1;
            o_strb.NEG = (i_opcode == OP_NEG); o_strb.NOT = (i_opcode == OP_NOT);
          end
          C_BR:       begin o_strb.Gra = 1'b1; o_strb.Rout = 1'b1; o_strb.CONin = 1'b1; end
          C_SINGLE: begin
            case (i_opcode)
              OP_JR:   begin o_strb.Gra = 1'b1; o_strb.Rout = 1'b1; o_strb.PCin = 1'b1; end
              OP_IN:   begin o_strb.InPortout = 1'b1; o_strb.Gra = 1'b1; o_strb.Rin = 1'b1; end
              OP_OUT:  begin o_strb.Gra = 1'b1; o_strb.Rout = 1'b1; o_strb.OutPortin = 1'b1; end
              OP_MFHI: begin o_strb.HIout = 1'b1; o_strb.Gra = 1'b1; o_strb.Rin = 1'b1; end
              default: begin o_strb.LOout = 1'b1; o_strb.Gra = 1'b1; o_strb.Rin = 1'b1; end
            endcase
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (w_class)
          C_RTYPE: begin
            o_strb.Grc = 1'b1; o_strb.Rout = 1'b1; o_strb.Zlowin = 1'b1;
            case (i_opcode)
              OP_ADD:  o_strb.ADD  = 1'b1;
              OP_SUB:  o_strb.SUB  = 1'b1;
              OP_AND:  o_strb.AND  = 1'b1;
              OP_OR:   o_strb.OR   = 1'b1;
              OP_SHR:  o_strb.SHR  = 1'b1;
              OP_SHRA: o_strb.SHRA = 1'b1;
              OP_SHL:  o_strb.SHL  = 1'b1;
              OP_ROR:  o_strb.ROR  = 1'b1;
              default: o_strb.ROL  = 1'b1;
            endcase
          end
          // ldi shares addi's adder path: base + sign-extended constant.
          C_IMM: begin
            o_strb.CSEout = 1'b1; o_strb.Zlowin = 1'b1;
            o_strb.AND = (i_opcode == OP_ANDI);
            o_strb.OR  = (i_opcode == OP_ORI);
            o_strb.ADD = (i_opcode == OP_ADDI) || (i_opcode == OP_LDI);
          end
          C_LD, C_ST: begin o_strb.CSEout = 1'b1; o_strb.ADD = 1'b1; o_strb.Zlowin = 1'b1; end
          C_MULDIV: begin
            o_strb.Grb = 1'b1; o_strb.Rout = 1'b1; o_strb.Zhighin = 1'b1; o_strb.Zlowin = 1'b1;
            o_strb.MUL = (i_opcode == OP_MUL); o_strb.DIV = (i_opcode == OP_DIV);
          end
          C_NEGNOT: begin o_strb.Zlowout = 1'b1; o_strb.Gra = 1'b1; o_strb.Rin = 1'b1; end
          C_BR:     begin o_strb.PCout = 1'b1; o_strb.Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (w_class)
          C_RTYPE, C_IMM: begin o_strb.Zlowout = 1'b1; o_strb.Gra = 1'b1; o_strb.Rin = 1'b1; end
          C_LD, C_ST:     begin o_strb.Zlowout = 1'b1; o_strb.MARin = 1'b1; end
          C_MULDIV:       begin o_strb.Zlowout = 1'b1; o_strb.LOin = 1'b1; end
          C_BR:           begin o_strb.CSEout = 1'b1; o_strb.ADD = 1'b1; o_strb.Zlowin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (w_class)
          C_LD:     begin o_strb.MDMuxread = 1'b1; o_strb.RAMread = 1'b1; o_strb.MDRin = 1'b1; end
          C_ST:     begin o_strb.Gra = 1'b1; o_strb.Rout = 1'b1; o_strb.MDRin = 1'b1; end
          C_MULDIV: begin o_strb.Zhighout = 1'b1; o_strb.HIin = 1'b1; end
          C_BR:     begin o_strb.Zlowout = i_con; o_strb.PCin = i_con; end
          default: ;
        endcase
      end
      S_T7: begin
        if (w_class == C_LD) begin
          o_strb.MDRout = 1'b1; o_strb.Gra = 1'b1; o_strb.Rin = 1'b1;
        end else if (w_class == C_ST) begin
          o_strb.RAMwrite = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Datapath control bus: state register and next-state
// logic; strobes come from control_decode. CTRL_STOP_EN adds the stop input and STOP state.
module control_unit
  import control_unit_pkg::*;
#(
  parameter opcode_t HALT_OP = HALT_OP_DEFAULT
) (
  input  logic clock,
  input  logic clear,
`ifdef CTRL_STOP_EN
  input  logic stop,
`endif
  control_unit_if.master ctrl,
  output state_t o_state
);

  state_t  r_state;
  state_t  w_next_state;
  state_t  w_t0_entry;
  opcode_t w_opcode;
  iclass_t w_class;
  logic    w_unused_ir;

  assign w_opcode    = ctrl.IR[31 -: OPCODE_W];
  assign w_unused_ir = ^ctrl.IR[31-OPCODE_W:0];
  assign w_class     = instr_class(w_opcode, HALT_OP);
  assign o_state     = r_state;

  // Every path back to T0 goes through here, so an in-flight instruction always finishes.
`ifdef CTRL_STOP_EN
  assign w_t0_entry = stop ? S_STOP : S_T0;
`else
  assign w_t0_entry = S_T0;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: w_next_state = w_t0_entry;
      S_T0:   w_next_state = S_T1;
      S_T1:   w_next_state = S_T2;
      S_T2: begin
        if (w_class == C_HALT)     w_next_state = S_HALT;
        else if (w_class == C_NOP) w_next_state = w_t0_entry;
        else                       w_next_state = S_T3;
      end
      S_T3:   w_next_state = (w_class == C_SINGLE) ? w_t0_entry : S_T4;
      S_T4:   w_next_state = (w_class == C_NEGNOT) ? w_t0_entry : S_T5;
      S_T5:   w_next_state = (w_class inside {C_RTYPE, C_IMM}) ? w_t0_entry : S_T6;
      S_T6:   w_next_state = (w_class inside {C_LD, C_ST}) ? S_T7 : w_t0_entry;
      S_T7:   w_next_state = w_t0_entry;
      S_HALT: w_next_state = S_HALT;
`ifdef CTRL_STOP_EN
      S_STOP: w_next_state = stop ? S_STOP : S_T0;
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  control_decode #(.HALT_OP(HALT_OP)) u_decode (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .i_con    (ctrl.ConFFQ),
    .o_strb   (ctrl.strb),
    .o_run    (ctrl.run)
  );

endmodule
